ip_cuckoo_hash_controller: RTL
==============================

Name: ip_cuckoo_hash_controller

Overview:
- Next-generation IP address set engine for the parser's filter path.
- Supports LOOKUP, INSERT and DELETE over NUM_TABLES hash tables using cuckoo displacement, bounded by MAX_KICKS, with a one-entry overflow stash.
- Sits between the header extractor, which issues lookups, and the host config path, which issues inserts and deletes.
- Single request/response port with a valid/ready request handshake; all table storage is internal.

Parameters:
- IP_ADDR_W, 32, key width in bits.
- KEY_W, 12, table index width; each table has 2**KEY_W entries.
- NUM_TABLES, 4, number of hash tables, range 2..4. Table t uses HASH_CRC_POLY[t] from hash_table_pkg.
- MAX_KICKS, 8, maximum evictions per insert before the stash is used.
- CNT_W, $clog2(NUM_TABLES*2**KEY_W+2), width of the occupancy counter.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- req_valid_i, in, 1: request valid.
- req_ready_o, out, 1: request ready; high only in IDLE.
- req_op_i, in, 2: 0 = LOOKUP, 1 = INSERT, 2 = DELETE, 3 = reserved (treated as LOOKUP).
- req_ip_i, in, IP_ADDR_W: key.
- resp_valid_o, out, 1: one-cycle response pulse.
- resp_status_o, out, 2: 0 = OK/HIT, 1 = MISS, 2 = DUPLICATE, 3 = FULL.
- resp_kicks_o, out, $clog2(MAX_KICKS+1): evictions performed by this request.
- occupancy_o, out, CNT_W: number of valid entries in the tables plus the stash.
- stash_valid_o, out, 1: stash occupied.

Behaviour:
- **Reset:** clears all table valid bits, the stash, occupancy_o, resp_* and kick counters. The FSM goes to IDLE and req_ready_o = 1 after reset deasserts. Reset asserted mid-operation aborts the request; no response is issued.
- **Index function:** idx_t = CRC over KEY_W bits.
  - Data = xor-fold of the key into KEY_W bits.
  - Poly = HASH_CRC_POLY[t]; init = all ones.
  - Computed combinationally from the current key register.
- **Entry format:** valid bit plus full IP_ADDR_W key. A hit requires the valid bit set and an exact full-key match.
- **Accept:** on req_valid_i && req_ready_o, latch op and key into cur_key and go to READ.
- **READ (1 cycle):** registered read of idx_t in every table, plus stash compare.
- **EVAL (1 cycle):** acts on the op.
  - LOOKUP: respond HIT if any table or the stash matches, else MISS. Response is in the cycle after EVAL, i.e. accept+3.
  - DELETE:
    - On a match, clear the matching valid bit (or the stash), decrement occupancy, respond OK.
    - Otherwise respond MISS.
    - A stash hit takes priority only if no table hits.
  - INSERT:
    - A match anywhere gives DUPLICATE with no change.
    - Else, if the stash is occupied and no table slot is free, respond FULL with no change.
    - Else write cur_key into the lowest-index table with a free slot, increment occupancy, respond OK.
    - Else go to KICK.
- **KICK:**
  - Victim table v = kick_ptr.
  - Write cur_key to table v at idx_v; cur_key takes the victim's key.
  - kick_ptr = (kick_ptr+1) mod NUM_TABLES; kicks++.
  - Return to READ. Each kick adds 3 cycles.
  - kick_ptr resets to 0 at each accepted insert.
- **Kick limit:** if kicks == MAX_KICKS at EVAL with no free slot, place cur_key in the stash (occupancy++), set stash_valid_o, respond OK with resp_kicks_o = MAX_KICKS.
  - Pre-check: FULL is decided only at the first EVAL, when the stash is already occupied. A stash made free by a DELETE becomes usable again.
- **RESP (1 cycle):** drive resp_valid_o = 1, then go to IDLE.
  - resp_status_o, resp_kicks_o hold their value until the next response.
  - req_ready_o = 0 from accept until RESP ends; back-to-back requests are accepted one cycle after RESP.
- **Occupancy:** never exceeds NUM_TABLES*2**KEY_W + 1. It changes only on INSERT OK (+1) and DELETE OK (-1).
- **Reserved op:** behaves exactly as LOOKUP.

Test Plan:
- Reset then LOOKUP 0x0A000001 -> resp_valid at accept+3, status MISS, occupancy_o 0, req_ready_o 1 two cycles after reset release.
- INSERT 0x0A000001 -> OK, kicks 0, occupancy 1. Repeat INSERT -> DUPLICATE, occupancy still 1. LOOKUP -> HIT.
- KEY_W=2, NUM_TABLES=2, MAX_KICKS=2: fill with 8 keys chosen to collide -> OK with nonzero kicks; every key still HITs on lookup.
- 9th colliding key -> OK, kicks=2, stash_valid_o=1, occupancy 9. 10th colliding key -> FULL, table contents unchanged (all 9 keys HIT).
- DELETE the stashed key -> OK, stash_valid_o=0, occupancy 8. DELETE the same key again -> MISS. Re-insert -> succeeds.
- Assert rst_n low during a KICK sequence -> no resp_valid_o, occupancy 0, all lookups MISS after reset.

Source files
------------

// File: rtl/ip_cuckoo_hash_controller.sv
// Cuckoo-hashed IP address set: LOOKUP / INSERT / DELETE over
// NUM_TABLES internal tables with bounded displacement and a one-entry stash.

package hash_table_pkg;
    localparam int MAX_TABLES = 4;

    // Per-table CRC generator polynomials; only the low KEY_W bits are used.
    // All are odd so every table's index map is a bijection of the fold.
    localparam logic [31:0] HASH_CRC_POLY [MAX_TABLES] = '{
        32'h0000_080F,
        32'h0000_0C11,
        32'h0000_0B41,
        32'h0000_0D7B
    };
endpackage

module ip_cuckoo_hash_controller
    import hash_table_pkg::*;
#(
    parameter int IP_ADDR_W  = 32,
    parameter int KEY_W      = 12,
    parameter int NUM_TABLES = 4,
    parameter int MAX_KICKS  = 8,
    parameter int CNT_W      = $clog2(NUM_TABLES * (2 ** KEY_W) + 2)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [1:0]                     req_op_i,
    input  logic [IP_ADDR_W-1:0]           req_ip_i,
    output logic                           resp_valid_o,
    output logic [1:0]                     resp_status_o,
    output logic [$clog2(MAX_KICKS+1)-1:0] resp_kicks_o,
    output logic [CNT_W-1:0]               occupancy_o,
    output logic                           stash_valid_o
);

    localparam int DEPTH  = 2 ** KEY_W;
    localparam int KICK_W = $clog2(MAX_KICKS + 1);
    localparam int TBL_W  = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1;
    localparam int FOLD_N = (IP_ADDR_W + KEY_W - 1) / KEY_W;

    localparam logic [1:0] OP_INSERT = 2'd1;
    localparam logic [1:0] OP_DELETE = 2'd2;

    localparam logic [1:0] ST_OK   = 2'd0;
    localparam logic [1:0] ST_MISS = 2'd1;
    localparam logic [1:0] ST_DUP  = 2'd2;
    localparam logic [1:0] ST_FULL = 2'd3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_EVAL = 3'd2;
    localparam logic [2:0] S_KICK = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]           state;
    logic [1:0]           cur_op;
    logic [IP_ADDR_W-1:0] cur_key;
    logic [KICK_W-1:0]    kicks;
    logic [TBL_W-1:0]     kick_ptr;
    logic [CNT_W-1:0]     occ;
    logic [1:0]           resp_status;
    logic [KICK_W-1:0]    resp_kicks;

    logic [IP_ADDR_W-1:0] stash_key;
    logic                 stash_vld;
    logic                 stash_hit_q;

    logic [IP_ADDR_W-1:0] tbl_key [NUM_TABLES][DEPTH];
    logic [DEPTH-1:0]     tbl_vld [NUM_TABLES];
    logic [IP_ADDR_W-1:0] rd_key  [NUM_TABLES];
    logic [NUM_TABLES-1:0] rd_vld;
    logic [KEY_W-1:0]     idx     [NUM_TABLES];

    logic [NUM_TABLES-1:0] hit_vec;
    logic                  any_hit;
    logic                  tbl_hit;
    logic                  any_free;
    logic [TBL_W-1:0]      free_sel;
    logic [TBL_W-1:0]      hit_sel;

    logic [NUM_TABLES-1:0] wr_en;
    logic [NUM_TABLES-1:0] clr_en;
    logic                  stash_set;
    logic                  stash_clr;
    logic                  occ_inc;
    logic                  occ_dec;
    logic                  go_kick;
    logic [1:0]            eval_status;

    logic is_ins;
    logic is_del;
    logic first_eval;

    // Xor-fold the key to KEY_W bits, then run an all-ones-seeded CRC over it.
    function automatic logic [KEY_W-1:0] crc_idx(
        input logic [IP_ADDR_W-1:0] key,
        input logic [KEY_W-1:0]     poly
    );
        logic [KEY_W-1:0] data;
        logic [KEY_W-1:0] crc;
        logic             fb;
        data = '0;
        for (int c = 0; c < FOLD_N; c++) begin
            data = data ^ KEY_W'(key >> (c * KEY_W));
        end
        crc = '1;
        for (int i = 0; i < KEY_W; i++) begin
            fb   = crc[KEY_W-1] ^ data[KEY_W-1];
            crc  = crc << 1;
            data = data << 1;
            if (fb) begin
                crc = crc ^ poly;
            end
        end
        return crc;
    endfunction

    assign req_ready_o   = (state == S_IDLE);
    assign resp_valid_o  = (state == S_RESP);
    assign resp_status_o = resp_status;
    assign resp_kicks_o  = resp_kicks;
    assign occupancy_o   = occ;
    assign stash_valid_o = stash_vld;

    assign is_ins     = (cur_op == OP_INSERT);
    assign is_del     = (cur_op == OP_DELETE);
    assign first_eval = (kicks == '0);

    // Per-table index derived from the key currently being processed.
    always_comb begin
        for (int t = 0; t < NUM_TABLES; t++) begin
            idx[t] = crc_idx(cur_key, HASH_CRC_POLY[t][KEY_W-1:0]);
        end
    end

    // Match / free-slot summary of the registered read, lowest table wins.
    always_comb begin
        hit_vec  = '0;
        any_free = 1'b0;
        free_sel = '0;
        hit_sel  = '0;
        for (int t = NUM_TABLES - 1; t >= 0; t--) begin
            hit_vec[t] = rd_vld[t] && (rd_key[t] == cur_key);
            if (!rd_vld[t]) begin
                any_free = 1'b1;
                free_sel = TBL_W'(t);
            end
            if (hit_vec[t]) begin
                hit_sel = TBL_W'(t);
            end
        end
        tbl_hit = |hit_vec;
        any_hit = tbl_hit || stash_hit_q;
    end

    // EVAL decision and KICK write strobes.
    always_comb begin
        wr_en       = '0;
        clr_en      = '0;
        stash_set   = 1'b0;
        stash_clr   = 1'b0;
        occ_inc     = 1'b0;
        occ_dec     = 1'b0;
        go_kick     = 1'b0;
        eval_status = ST_MISS;
        if (state == S_EVAL) begin
            unique case (1'b1)
                is_ins: begin
                    if (first_eval && any_hit) begin
                        eval_status = ST_DUP;
                    end else if (first_eval && stash_vld && !any_free) begin
                        eval_status = ST_FULL;
                    end else if (any_free) begin
                        wr_en[free_sel] = 1'b1;
                        occ_inc         = 1'b1;
                        eval_status     = ST_OK;
                    end else if (kicks == KICK_W'(MAX_KICKS)) begin
                        stash_set   = 1'b1;
                        occ_inc     = 1'b1;
                        eval_status = ST_OK;
                    end else begin
                        go_kick = 1'b1;
                    end
                end
                is_del: begin
                    if (tbl_hit) begin
                        clr_en[hit_sel] = 1'b1;
                        occ_dec         = 1'b1;
                        eval_status     = ST_OK;
                    end else if (stash_hit_q) begin
                        stash_clr   = 1'b1;
                        occ_dec     = 1'b1;
                        eval_status = ST_OK;
                    end
                end
                default: begin
                    eval_status = any_hit ? ST_OK : ST_MISS;
                end
            endcase
        end else if (state == S_KICK) begin
            wr_en[kick_ptr] = 1'b1;
        end
    end

    // Key storage and registered read; contents are qualified by tbl_vld.
    always_ff @(posedge clk) begin
        for (int t = 0; t < NUM_TABLES; t++) begin
            if (wr_en[t]) begin
                tbl_key[t][idx[t]] <= cur_key;
            end
            if (state == S_READ) begin
                rd_key[t] <= tbl_key[t][idx[t]];
            end
        end
    end

    // Entry valid bits: set on any table write, cleared by DELETE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_TABLES; t++) begin
                tbl_vld[t] <= '0;
            end
        end else begin
            for (int t = 0; t < NUM_TABLES; t++) begin
                if (wr_en[t]) begin
                    tbl_vld[t][idx[t]] <= 1'b1;
                end else if (clr_en[t]) begin
                    tbl_vld[t][idx[t]] <= 1'b0;
                end
            end
        end
    end

    // Request FSM, displacement bookkeeping, stash, occupancy and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cur_op      <= '0;
            cur_key     <= '0;
            kicks       <= '0;
            kick_ptr    <= '0;
            stash_key   <= '0;
            stash_vld   <= 1'b0;
            stash_hit_q <= 1'b0;
            rd_vld      <= '0;
            occ         <= '0;
            resp_status <= '0;
            resp_kicks  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        cur_op  <= req_op_i;
                        cur_key <= req_ip_i;
                        kicks   <= '0;
                        if (req_op_i == OP_INSERT) begin
                            kick_ptr <= '0;
                        end
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    for (int t = 0; t < NUM_TABLES; t++) begin
                        rd_vld[t] <= tbl_vld[t][idx[t]];
                    end
                    stash_hit_q <= stash_vld && (stash_key == cur_key);
                    state       <= S_EVAL;
                end
                S_EVAL: begin
                    if (stash_set) begin
                        stash_key <= cur_key;
                        stash_vld <= 1'b1;
                    end else if (stash_clr) begin
                        stash_vld <= 1'b0;
                    end
                    if (occ_inc) begin
                        occ <= occ + CNT_W'(1);
                    end else if (occ_dec) begin
                        occ <= occ - CNT_W'(1);
                    end
                    if (go_kick) begin
                        state <= S_KICK;
                    end else begin
                        resp_status <= eval_status;
                        resp_kicks  <= kicks;
                        state       <= S_RESP;
                    end
                end
                S_KICK: begin
                    cur_key <= rd_key[kick_ptr];
                    kicks   <= kicks + KICK_W'(1);
                    if (kick_ptr == TBL_W'(NUM_TABLES - 1)) begin
                        kick_ptr <= '0;
                    end else begin
                        kick_ptr <= kick_ptr + TBL_W'(1);
                    end
                    state <= S_READ;
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
